// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Default 640x480@60 timing constants and derived line/frame totals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int c_cnt_w    = 10;
    localparam int c_div_w    = 4;

    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;

    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;

    localparam int c_sync_pol = 0;

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    localparam int c_h_total  = axis_total(c_h_active, c_h_fp, c_h_sync, c_h_bp);
    localparam int c_v_total  = axis_total(c_v_active, c_v_fp, c_v_sync, c_v_bp);

endpackage

`default_nettype wire

// File: rtl/vga_timing_if.sv
// ============================================================================
// Module   : vga_timing_if
// Brief    : Raster position/sync bus between the timing generator and its users.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_timing_if;
    import vga_timing_pkg::*;

    logic                 pause;
    logic [c_div_w-1:0]   frame_div;
    logic [c_cnt_w-1:0]   x;
    logic [c_cnt_w-1:0]   y;
    logic                 active;
    logic                 hsync;
    logic                 vsync;
    logic                 next_frame;

    modport master (
        input  pause, frame_div,
        output x, y, active, hsync, vsync, next_frame
    );

    modport slave (
        output pause, frame_div,
        input  x, y, active, hsync, vsync, next_frame
    );

endinterface

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
// Module   : vga_timing
// Brief    : VGA raster counters, sync/active generation and a frame-advance
//            pulse; the frame divider is built only with VGA_FRAME_DIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter int SYNC_POL = c_sync_pol
) (
    input  wire logic     clk,
    input  wire logic     rst,
    vga_timing_if.master  bus
);

    localparam int               c_h_tot   = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int               c_v_tot   = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [c_cnt_w-1:0] c_h_max   = c_cnt_w'(c_h_tot - 1);
    localparam logic [c_cnt_w-1:0] c_v_max   = c_cnt_w'(c_v_tot - 1);
    localparam logic [c_cnt_w-1:0] c_h_act   = c_cnt_w'(H_ACTIVE);
    localparam logic [c_cnt_w-1:0] c_v_act   = c_cnt_w'(V_ACTIVE);
    localparam logic [c_cnt_w-1:0] c_hs_beg  = c_cnt_w'(H_ACTIVE + H_FP);
    localparam logic [c_cnt_w-1:0] c_hs_end  = c_cnt_w'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [c_cnt_w-1:0] c_vs_beg  = c_cnt_w'(V_ACTIVE + V_FP);
    localparam logic [c_cnt_w-1:0] c_vs_end  = c_cnt_w'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic               c_sync_on = (SYNC_POL != 0);

    logic [c_cnt_w-1:0] r_x;
    logic [c_cnt_w-1:0] r_y;
    logic               r_active;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_next_frame;

    logic [c_cnt_w-1:0] w_x_nxt;
    logic [c_cnt_w-1:0] w_y_nxt;
    logic               w_h_wrap;
    logic               w_frame_evt;
    logic               w_hs_on;
    logic               w_vs_on;
    logic               w_fire;

    // Every registered flag is decoded from the next counter values so it
    // lines up with x/y in the same cycle.
    always_comb begin
        w_h_wrap    = (r_x == c_h_max);
        w_x_nxt     = w_h_wrap ? '0 : r_x + 1'b1;
        w_y_nxt     = r_y;
        if (w_h_wrap) begin
            w_y_nxt = (r_y == c_v_max) ? '0 : r_y + 1'b1;
        end
        w_frame_evt = (w_x_nxt == '0) && (w_y_nxt == c_v_act);
        w_hs_on     = (w_x_nxt >= c_hs_beg) && (w_x_nxt <= c_hs_end);
        w_vs_on     = (w_y_nxt >= c_vs_beg) && (w_y_nxt <= c_vs_end);
    end

`ifdef VGA_FRAME_DIV_EN
    logic [c_div_w-1:0] r_div_cnt;
    logic               w_div_hit;

    assign w_div_hit = (r_div_cnt >= bus.frame_div);
    assign w_fire    = w_frame_evt && !bus.pause && w_div_hit;

    // A paused frame event leaves the count untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_frame_evt && !bus.pause) begin
            r_div_cnt <= w_div_hit ? '0 : r_div_cnt + 1'b1;
        end
    end
`else
    logic w_unused_frame_div;

    assign w_unused_frame_div = ^bus.frame_div;
    assign w_fire             = w_frame_evt && !bus.pause;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_active     <= 1'b0;
            r_hsync      <= !c_sync_on;
            r_vsync      <= !c_sync_on;
            r_next_frame <= 1'b0;
        end else begin
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_active     <= (w_x_nxt < c_h_act) && (w_y_nxt < c_v_act);
            r_hsync      <= w_hs_on ? c_sync_on : !c_sync_on;
            r_vsync      <= w_vs_on ? c_sync_on : !c_sync_on;
            r_next_frame <= w_fire;
        end
    end

    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.active     = r_active;
    assign bus.hsync      = r_hsync;
    assign bus.vsync      = r_vsync;
    assign bus.next_frame = r_next_frame;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
// ============================================================================
// Module   : tb_vga_timing
// Brief    : Self-checking bench for vga_timing on a scaled-down raster.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing;

    // Scaled raster keeps whole-frame scenarios short.
    localparam int TH_ACT  = 40;
    localparam int TH_FP   = 4;
    localparam int TH_SYNC = 6;
    localparam int TH_BP   = 6;
    localparam int TV_ACT  = 12;
    localparam int TV_FP   = 2;
    localparam int TV_SYNC = 2;
    localparam int TV_BP   = 3;
    localparam int HT      = TH_ACT + TH_FP + TH_SYNC + TH_BP;
    localparam int VT      = TV_ACT + TV_FP + TV_SYNC + TV_BP;
    localparam int FRAME   = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_timing_if vif();

    vga_timing #(
        .H_ACTIVE (TH_ACT),
        .H_FP     (TH_FP),
        .H_SYNC   (TH_SYNC),
        .H_BP     (TH_BP),
        .V_ACTIVE (TV_ACT),
        .V_FP     (TV_FP),
        .V_SYNC   (TV_SYNC),
        .V_BP     (TV_BP),
        .SYNC_POL (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: position is the number of clocks since reset release.
    int   m_n      = 0;
    logic m_rst    = 1'b1;
    int   m_since  = 0;
    logic m_pulse  = 1'b0;
    int   m_pulses = 0;

    function automatic int mx();
        return m_rst ? 0 : m_n % HT;
    endfunction

    function automatic int my();
        return m_rst ? 0 : (m_n / HT) % VT;
    endfunction

    function automatic logic [23:0] exp_vec();
        int   ex, ey;
        logic a, h, v;
        if (m_rst) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        ex = mx();
        ey = my();
        a  = (ex < TH_ACT) && (ey < TV_ACT);
        h  = !((ex >= TH_ACT + TH_FP) && (ex < TH_ACT + TH_FP + TH_SYNC));
        v  = !((ey >= TV_ACT + TV_FP) && (ey < TV_ACT + TV_FP + TV_SYNC));
        return {10'(ex), 10'(ey), a, h, v, m_pulse};
    endfunction

    function automatic logic [23:0] dut_vec();
        return {vif.x, vif.y, vif.active, vif.hsync, vif.vsync, vif.next_frame};
    endfunction

    task automatic model_reset();
        m_rst   = 1'b1;
        m_n     = 0;
        m_since = 0;
        m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic p, input logic [3:0] fd);
        if (r) begin
            model_reset();
        end else begin
            m_rst   = 1'b0;
            m_n++;
            m_pulse = 1'b0;
            if (mx() == 0 && my() == TV_ACT && !p) begin
`ifdef VGA_FRAME_DIV_EN
                if (m_since >= int'(fd)) begin
                    m_pulse = 1'b1;
                    m_since = 0;
                end else begin
                    m_since++;
                end
`else
                m_pulse = (fd <= 4'd15);
`endif
            end
            if (m_pulse) m_pulses++;
        end
    endtask

    task automatic tick();
        logic       r, p;
        logic [3:0] fd;
        r  = rst;
        p  = vif.pause;
        fd = vif.frame_div;
        @(posedge clk);
        #1;
        model_step(r, p, fd);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        vif.pause     = 1'b0;
        vif.frame_div = 4'd0;
        rst           = 1'b1;
        model_reset();
        repeat (3) tick();
        n_checks++; if (vif.x !== 10'd0)         $display("FAIL reset_x: got %0d expected 0", vif.x); else n_pass++;
        n_checks++; if (vif.y !== 10'd0)         $display("FAIL reset_y: got %0d expected 0", vif.y); else n_pass++;
        n_checks++; if (vif.active !== 1'b0)     $display("FAIL reset_active: got %b expected 0", vif.active); else n_pass++;
        n_checks++; if (vif.hsync !== 1'b1)      $display("FAIL reset_hsync: got %b expected 1", vif.hsync); else n_pass++;
        n_checks++; if (vif.vsync !== 1'b1)      $display("FAIL reset_vsync: got %b expected 1", vif.vsync); else n_pass++;
        n_checks++; if (vif.next_frame !== 1'b0) $display("FAIL reset_next_frame: got %b expected 0", vif.next_frame); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (vif.x !== 10'd1)         $display("FAIL release_x: got %0d expected 1", vif.x); else n_pass++;
        n_checks++; if (vif.y !== 10'd0)         $display("FAIL release_y: got %0d expected 0", vif.y); else n_pass++;
        n_checks++; if (vif.active !== 1'b1)     $display("FAIL release_active: got %b expected 1", vif.active); else n_pass++;
    endtask

    task automatic test_line();
        int          errs = 0, hs_low = 0, hs_first = -1;
        logic [23:0] fo = '0, fe = '0;
        repeat (HT - 1) begin
            tick();
            if (dut_vec() !== exp_vec()) begin
                if (errs == 0) begin fo = dut_vec(); fe = exp_vec(); end
                errs++;
            end
            if (vif.hsync === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(vif.x);
            end
        end
        n_checks++; if (errs !== 0)   $display("FAIL line_seq: %0d bad cycles, first got %h expected %h", errs, fo, fe); else n_pass++;
        n_checks++; if (hs_low !== TH_SYNC) $display("FAIL line_hsync_width: got %0d expected %0d", hs_low, TH_SYNC); else n_pass++;
        n_checks++; if (hs_first !== TH_ACT + TH_FP) $display("FAIL line_hsync_start: got %0d expected %0d", hs_first, TH_ACT + TH_FP); else n_pass++;
        n_checks++; if ({vif.x, vif.y} !== {10'd0, 10'd1}) $display("FAIL line_wrap: got x=%0d y=%0d expected x=0 y=1", vif.x, vif.y); else n_pass++;
    endtask

    task automatic test_frame();
        int          errs = 0, act = 0, vs_low = 0, vs_first = -1, dp = 0, mp0;
        logic [23:0] fo = '0, fe = '0;
        mp0 = m_pulses;
        repeat (FRAME) begin
            tick();
            if (dut_vec() !== exp_vec()) begin
                if (errs == 0) begin fo = dut_vec(); fe = exp_vec(); end
                errs++;
            end
            if (vif.active === 1'b1) act++;
            if (vif.next_frame === 1'b1) dp++;
            if (vif.vsync === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = int'(vif.y);
            end
        end
        n_checks++; if (errs !== 0) $display("FAIL frame_seq: %0d bad cycles, first got %h expected %h", errs, fo, fe); else n_pass++;
        n_checks++; if (act !== TH_ACT * TV_ACT) $display("FAIL frame_active_count: got %0d expected %0d", act, TH_ACT * TV_ACT); else n_pass++;
        n_checks++; if (vs_low !== TV_SYNC * HT) $display("FAIL frame_vsync_cycles: got %0d expected %0d", vs_low, TV_SYNC * HT); else n_pass++;
        n_checks++; if (vs_first !== TV_ACT + TV_FP) $display("FAIL frame_vsync_line: got %0d expected %0d", vs_first, TV_ACT + TV_FP); else n_pass++;
        n_checks++; if (dp !== m_pulses - mp0) $display("FAIL frame_pulses: got %0d expected %0d", dp, m_pulses - mp0); else n_pass++;
    endtask

    task automatic test_divider();
        int          errs = 0, dp = 0, bad_pos = 0, dbl = 0, exp_cnt;
        logic        prev = 1'b0;
        logic [23:0] fo = '0, fe = '0;
        vif.pause     = 1'b0;
        vif.frame_div = 4'd2;
        do_reset();
`ifdef VGA_FRAME_DIV_EN
        exp_cnt = 2;
`else
        exp_cnt = 6;
`endif
        repeat (6 * FRAME) begin
            tick();
            if (dut_vec() !== exp_vec()) begin
                if (errs == 0) begin fo = dut_vec(); fe = exp_vec(); end
                errs++;
            end
            if (vif.next_frame === 1'b1) begin
                dp++;
                if (vif.x !== 10'd0 || vif.y !== 10'(TV_ACT)) bad_pos++;
                if (prev === 1'b1) dbl++;
            end
            prev = vif.next_frame;
        end
        n_checks++; if (errs !== 0) $display("FAIL div_seq: %0d bad cycles, first got %h expected %h", errs, fo, fe); else n_pass++;
        n_checks++; if (dp !== exp_cnt) $display("FAIL div_pulse_count: got %0d expected %0d", dp, exp_cnt); else n_pass++;
        n_checks++; if (bad_pos !== 0) $display("FAIL div_pulse_position: got %0d misplaced expected 0", bad_pos); else n_pass++;
        n_checks++; if (dbl !== 0) $display("FAIL div_pulse_width: got %0d wide pulses expected 0", dbl); else n_pass++;
    endtask

    task automatic test_pause();
        int          errs = 0, dp_paused = 0, dp_run = 0, mp0;
        logic [23:0] fo = '0, fe = '0;
        vif.pause = 1'b1;
        repeat (2 * FRAME) begin
            tick();
            if (dut_vec() !== exp_vec()) begin
                if (errs == 0) begin fo = dut_vec(); fe = exp_vec(); end
                errs++;
            end
            if (vif.next_frame === 1'b1) dp_paused++;
        end
        vif.pause     = 1'b0;
        vif.frame_div = 4'($urandom_range(0, 3));
        mp0           = m_pulses;
        repeat (4 * FRAME) begin
            tick();
            if (dut_vec() !== exp_vec()) begin
                if (errs == 0) begin fo = dut_vec(); fe = exp_vec(); end
                errs++;
            end
            if (vif.next_frame === 1'b1) dp_run++;
        end
        n_checks++; if (errs !== 0) $display("FAIL pause_seq: %0d bad cycles, first got %h expected %h", errs, fo, fe); else n_pass++;
        n_checks++; if (dp_paused !== 0) $display("FAIL pause_suppress: got %0d pulses expected 0", dp_paused); else n_pass++;
        n_checks++; if (dp_run !== m_pulses - mp0) $display("FAIL pause_resume: got %0d pulses expected %0d", dp_run, m_pulses - mp0); else n_pass++;
        n_checks++; if (dp_run == 0) $display("FAIL pause_resume_any: got 0 pulses expected at least 1"); else n_pass++;
    endtask

    task automatic test_random();
        int          errs = 0, dp = 0, mp0;
        logic [23:0] fo = '0, fe = '0;
        mp0 = m_pulses;
        repeat (8 * FRAME) begin
            tick();
            if (dut_vec() !== exp_vec()) begin
                if (errs == 0) begin fo = dut_vec(); fe = exp_vec(); end
                errs++;
            end
            if (vif.next_frame === 1'b1) dp++;
            if ($urandom_range(0, HT - 1) == 0) vif.pause = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2 * HT) == 0) vif.frame_div = 4'($urandom_range(0, 3));
        end
        vif.pause = 1'b0;
        n_checks++; if (errs !== 0) $display("FAIL random_seq: %0d bad cycles, first got %h expected %h", errs, fo, fe); else n_pass++;
        n_checks++; if (dp !== m_pulses - mp0) $display("FAIL random_pulses: got %0d expected %0d", dp, m_pulses - mp0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int          errs = 0, guard = 0, stray = 0;
        logic [23:0] fo = '0, fe = '0;
        while (!(mx() == 20 && my() == 7) && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        n_checks++; if (guard >= 2 * FRAME) $display("FAIL midrst_reach: got timeout expected position x=20 y=7"); else n_pass++;
        n_checks++; if ({vif.x, vif.y} !== {10'd20, 10'd7}) $display("FAIL midrst_position: got x=%0d y=%0d expected x=20 y=7", vif.x, vif.y); else n_pass++;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (dut_vec() !== exp_vec()) $display("FAIL midrst_immediate: got %h expected %h", dut_vec(), exp_vec()); else n_pass++;
        repeat (5) begin
            tick();
            if (vif.next_frame === 1'b1) stray++;
        end
        rst = 1'b0;
        tick();
        if (vif.next_frame === 1'b1) stray++;
        n_checks++; if ({vif.x, vif.y} !== {10'd1, 10'd0}) $display("FAIL midrst_release: got x=%0d y=%0d expected x=1 y=0", vif.x, vif.y); else n_pass++;
        // Second reset at a random point, then a full frame must follow the model.
        repeat ($urandom_range(1, FRAME)) tick();
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (dut_vec() !== exp_vec()) $display("FAIL midrst_random_immediate: got %h expected %h", dut_vec(), exp_vec()); else n_pass++;
        repeat (5) begin
            tick();
            if (vif.next_frame === 1'b1) stray++;
        end
        rst = 1'b0;
        repeat (FRAME + 1) begin
            tick();
            if (dut_vec() !== exp_vec()) begin
                if (errs == 0) begin fo = dut_vec(); fe = exp_vec(); end
                errs++;
            end
        end
        n_checks++; if (stray !== 0) $display("FAIL midrst_stray_pulse: got %0d pulses expected 0", stray); else n_pass++;
        n_checks++; if (errs !== 0) $display("FAIL midrst_resume_seq: %0d bad cycles, first got %h expected %h", errs, fo, fe); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_divider();
        test_pause();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
